regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, giving the data width of each register in bits.
REQ-002 The block SHALL have the parameter ADDR_W, default 5, giving the register address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port ctrl_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have the port ctrl_writeEnable, input, 1 bit: writeback strobe.
REQ-006 The block SHALL have the port ctrl_writeReg, input, ADDR_W bits: writeback destination.
REQ-007 The block SHALL have the port data_writeReg, input, WIDTH bits: writeback data.
REQ-008 The block SHALL have the ports ctrl_readRegA and ctrl_readRegB, input, ADDR_W bits each: read addresses.
REQ-009 The block SHALL have the ports data_readRegA and data_readRegB, output, WIDTH bits each: read data.
REQ-010 The block SHALL have the ports busyA and busyB, output, 1 bit each: the addressed source register has a pending write.
REQ-011 The block SHALL have the port ctrl_issueEnable, input, 1 bit: request to reserve a destination register.
REQ-012 The block SHALL have the port ctrl_issueReg, input, ADDR_W bits: the register to reserve.
REQ-013 The block SHALL have the port issue_stall, output, 1 bit: the issue request is refused this cycle.
REQ-014 The block SHALL have the port pending_count, output, ADDR_W+1 bits: the number of reserved registers.
REQ-015 The block SHALL have the port dbg_sel, input, ADDR_W bits: debug tap select.
REQ-016 The block SHALL have the port dbg_data, output, WIDTH bits: contents of the debug-selected register.

Function
REQ-017 Register 0 SHALL read as all-zero at all times; writes to it SHALL be ignored, issues to it SHALL be ignored, and it SHALL never be pending.
REQ-018 Reads SHALL be combinational: data_readRegX equals the stored value of register ctrl_readRegX in the same cycle.
REQ-019 A write with ctrl_writeEnable=1 and ctrl_writeReg!=0 SHALL update that register at the rising edge; the new value is visible the following cycle.
REQ-020 The scoreboard SHALL hold one pending bit per register: an accepted issue sets the bit and a write clears it.
REQ-021 A write to a register that is not pending SHALL still be performed, with no error.
REQ-022 issue_stall SHALL be 1 when ctrl_issueEnable=1, ctrl_issueReg!=0, the target is already pending, and it is not being written in the same cycle (WAW hazard); a stalled issue SHALL have no effect.
REQ-023 When an issue and a write target the same register in the same cycle, the write SHALL complete and the pending bit SHALL remain 1.
REQ-024 busyX SHALL equal the registered pending bit of ctrl_readRegX, and SHALL be 0 for register 0.
REQ-025 pending_count SHALL equal the population count of the pending bits, updated the same edge as those bits; its range is 0..DEPTH-1.
REQ-026 dbg_data SHALL combinationally return register dbg_sel; register 0 returns 0; no bypass applies to dbg_data.
REQ-027 Read port A, read port B and dbg_sel SHALL be fully independent and may all address the same register.

Reset
REQ-028 When ctrl_reset=1 at a rising edge, every register and every pending bit SHALL be cleared, so that all read outputs, dbg_data and pending_count are 0 and busyA, busyB and issue_stall are 0.
REQ-029 Reset SHALL dominate any write or issue presented in the same cycle, including in the middle of operation.

Configuration
REQ-030 When the macro REGFILE_BYPASS_EN is defined and ctrl_writeEnable=1 with ctrl_writeReg==ctrl_readRegX!=0, data_readRegX SHALL return data_writeReg in the same cycle.
REQ-031 Under the same condition with REGFILE_BYPASS_EN defined, busyX SHALL be 0 unless a same-cycle issue to that register is accepted.
REQ-032 When REGFILE_BYPASS_EN is undefined, reads SHALL return only stored values and busyX SHALL follow REQ-024 unchanged.

Verification
REQ-033 Reset, then write 0xDEADBEEF to r5, then read A=r5 the next cycle -> data_readRegA=0xDEADBEEF; read B=r0 -> 0.
REQ-034 Write 0x12345678 to r0, then read r0 -> 0; issue r0 -> pending_count stays 0 and issue_stall=0.
REQ-035 Issue r3, then issue r3 again -> second issue gives issue_stall=1 and pending_count=1; busyA=1 for readRegA=r3; write r3 -> busyA=0 and pending_count=0 the next cycle.
REQ-036 With r7 pending, write r7 and issue r7 in the same cycle -> r7 is updated, pending remains set, and pending_count is unchanged.
REQ-037 Write r9=0xA5A5A5A5 with readRegA=r9 in the same cycle -> with REGFILE_BYPASS_EN the result is 0xA5A5A5A5 in that cycle; without it the result is the old value, with the new value the next cycle.
REQ-038 Issue r1, r2, r3 and write r4=1, then assert ctrl_reset -> the next cycle all registers and pending_count are 0, and dbg_sel=4 gives dbg_data=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a one-bit-per-register write scoreboard.
// - Two combinational read ports and a combinational debug tap.
// - One write port; a write clears the destination's pending bit.
// - One issue port; reserving an already-pending register is refused (WAW).
// - Register 0 is hard-wired to zero and can never be pending.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data
// (and the resulting busy state) to the read ports.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]  data_readRegA,
    output logic [WIDTH-1:0]  data_readRegB,
    output logic              busyA,
    output logic              busyB,
    input  logic              ctrl_issueEnable,
    input  logic [ADDR_W-1:0] ctrl_issueReg,
    output logic              issue_stall,
    output logic [ADDR_W:0]   pending_count,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    logic write_ok;
    logic issue_hit;
    logic issue_acc;
    logic stall;

    // Qualify write and issue requests; register 0 never takes part.
    always_comb begin
        write_ok  = ctrl_writeEnable && (ctrl_writeReg != '0);
        issue_hit = ctrl_issueEnable && (ctrl_issueReg != '0);
        // A same-cycle write to the target retires the old reservation,
        // so the new issue can take over without a WAW stall.
        stall     = issue_hit && pend_q[ctrl_issueReg]
                    && !(write_ok && (ctrl_writeReg == ctrl_issueReg));
        issue_acc = issue_hit && !stall;
    end

    // Scoreboard next state: write clears first, accepted issue sets last,
    // so a write and issue to the same register leave it pending.
    always_comb begin
        pend_d = pend_q;
        if (write_ok) begin
            pend_d[ctrl_writeReg] = 1'b0;
        end
        if (issue_acc) begin
            pend_d[ctrl_issueReg] = 1'b1;
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_ok) begin
            regs_q[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Scoreboard bits and their population count, updated together.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    // Read ports, busy flags and debug tap.
    always_comb begin
        data_readRegA = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
        data_readRegB = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];
        busyA         = pend_q[ctrl_readRegA];
        busyB         = pend_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        // Forwarded reads see the post-write scoreboard: free unless the
        // same register is re-reserved in this cycle.
        if (write_ok && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busyA         = pend_d[ctrl_readRegA];
        end
        if (write_ok && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busyB         = pend_d[ctrl_readRegB];
        end
`else
`endif
        dbg_data      = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
        issue_stall   = stall;
        pending_count = count_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: reference model of the register file plus directed vectors.
module tb_regfile_sb;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busyA;
    logic        busyB;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic        issue_stall;
    logic [5:0]  pending_count;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];

    regfile_sb #(.WIDTH(32), .ADDR_W(5)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .busyA            (busyA),
        .busyB            (busyB),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .issue_stall      (issue_stall),
        .pending_count    (pending_count),
        .dbg_sel          (dbg_sel),
        .dbg_data         (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model view of the current cycle's combinational outputs.
    function automatic bit m_stall();
        return ctrl_issueEnable && ctrl_issueReg != 0 && m_pend[ctrl_issueReg]
               && !(ctrl_writeEnable && ctrl_writeReg == ctrl_issueReg);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
`endif
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg == a)
            return ctrl_issueEnable && ctrl_issueReg == a;
`endif
        return m_pend[a];
    endfunction

    function automatic logic [31:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
        return n;
    endfunction

    // Model state update at each rising edge.
    always @(posedge clock) begin
        bit st;
        st = m_stall();
        if (ctrl_reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (ctrl_writeEnable && ctrl_writeReg != 0) begin
                m_mem[ctrl_writeReg]  = data_writeReg;
                m_pend[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_issueEnable && ctrl_issueReg != 0 && !st)
                m_pend[ctrl_issueReg] = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cmp_rdA",   data_readRegA, m_rd(ctrl_readRegA));
            chk("cmp_rdB",   data_readRegB, m_rd(ctrl_readRegB));
            chk("cmp_busyA", {31'b0, busyA}, {31'b0, m_busy(ctrl_readRegA)});
            chk("cmp_busyB", {31'b0, busyB}, {31'b0, m_busy(ctrl_readRegB)});
            chk("cmp_stall", {31'b0, issue_stall}, {31'b0, m_stall()});
            chk("cmp_count", {26'b0, pending_count}, m_cnt());
            chk("cmp_dbg",   dbg_data, (dbg_sel == 0) ? 32'h0 : m_mem[dbg_sel]);
        end
    end

    task automatic drv(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ir,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] sel);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_issueEnable = ie;
        ctrl_issueReg    = ir;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        dbg_sel          = sel;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        tick();
        tick();
        ctrl_reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_rdA",  data_readRegA, 32'h0);
        chk("rst_cnt",  {26'b0, pending_count}, 32'h0);
        chk("rst_busy", {30'b0, busyA, busyB}, 32'h0);

        // Write then read back; r0 reads zero.
        drv(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 5);
        tick();
        drv(0, 0, 0, 0, 0, 5, 0, 5);
        chk("wr5_rdA", data_readRegA, 32'hDEADBEEF);
        chk("wr5_rdB", data_readRegB, 32'h0);
        chk("wr5_dbg", dbg_data, 32'hDEADBEEF);

        // Register 0 ignores writes and issues.
        drv(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_rd",    data_readRegA, 32'h0);
        chk("r0_stall", {31'b0, issue_stall}, 32'h0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_cnt", {26'b0, pending_count}, 32'h0);

        // WAW stall on re-issue, then write releases.
        drv(0, 0, 0, 1, 3, 3, 0, 0);
        tick();
        drv(0, 0, 0, 1, 3, 3, 0, 0);
        chk("waw_stall", {31'b0, issue_stall}, 32'h1);
        chk("waw_cnt",   {26'b0, pending_count}, 32'h1);
        chk("waw_busyA", {31'b0, busyA}, 32'h1);
        tick();
        drv(1, 3, 32'h33, 0, 0, 3, 0, 0);
        chk("waw_cnt2", {26'b0, pending_count}, 32'h1);
        tick();
        drv(0, 0, 0, 0, 0, 3, 0, 0);
        chk("rel_busyA", {31'b0, busyA}, 32'h0);
        chk("rel_cnt",   {26'b0, pending_count}, 32'h0);

        // Same-cycle write and issue to a pending register.
        drv(0, 0, 0, 1, 7, 0, 0, 0);
        tick();
        drv(1, 7, 32'h77, 1, 7, 0, 0, 0);
        chk("wi7_stall", {31'b0, issue_stall}, 32'h0);
        tick();
        drv(0, 0, 0, 0, 0, 7, 7, 7);
        chk("wi7_rdA",  data_readRegA, 32'h77);
        chk("wi7_busy", {31'b0, busyA}, 32'h1);
        chk("wi7_cnt",  {26'b0, pending_count}, 32'h1);

        // Same-cycle read of a register being written.
        drv(1, 9, 32'hA5A5A5A5, 0, 0, 9, 0, 9);
`ifdef REGFILE_BYPASS_EN
        chk("byp_rdA", data_readRegA, 32'hA5A5A5A5);
`else
        chk("byp_rdA", data_readRegA, 32'h0);
`endif
        chk("byp_dbg", dbg_data, 32'h0);
        tick();
        drv(0, 0, 0, 0, 0, 9, 9, 9);
        chk("byp_next", data_readRegA, 32'hA5A5A5A5);

        // Top address, all three read taps on one register.
        drv(0, 0, 0, 1, 31, 0, 0, 0);
        tick();
        drv(1, 31, 32'hFFFF0001, 0, 0, 31, 31, 31);
        tick();
        drv(0, 0, 0, 0, 0, 31, 31, 31);
        chk("r31_rdA", data_readRegA, 32'hFFFF0001);
        chk("r31_rdB", data_readRegB, 32'hFFFF0001);
        chk("r31_dbg", dbg_data, 32'hFFFF0001);

        // Mid-operation reset dominates pending write/issue.
        drv(0, 0, 0, 1, 1, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 2, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 3, 0, 0, 0); tick();
        drv(1, 4, 32'h1, 0, 0, 0, 0, 4); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 4);
        chk("pre_rst_cnt", {26'b0, pending_count}, 32'h4);
        chk("pre_rst_dbg", dbg_data, 32'h1);
        ctrl_reset = 1'b1;
        drv(1, 10, 32'hCAFE, 1, 11, 0, 0, 4);
        tick();
        ctrl_reset = 1'b0;
        drv(0, 0, 0, 0, 0, 10, 11, 4);
        chk("rst2_dbg",   dbg_data, 32'h0);
        chk("rst2_cnt",   {26'b0, pending_count}, 32'h0);
        chk("rst2_rdA",   data_readRegA, 32'h0);
        chk("rst2_busyB", {31'b0, busyB}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            dbg_sel = i[4:0];
            #0;
            chk("rst2_all", dbg_data, 32'h0);
        end

        // Mixed traffic over a small address window.
        for (int n = 0; n < 300; n++) begin
            drv($urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom,
                $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)),
                5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
            ctrl_reset = ($urandom_range(60, 0) == 0);
            tick();
        end
        ctrl_reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
